// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage and the decode logic
// that consumes its IF/ID register.
//   - fetch_state_e : fetch FSM states
//   - NOP_INSTR     : canonical NOP (addi x0,x0,0) used to fill empty slots
//   - OPC_*         : major opcodes decoded from if_id_opcode
//   - DEFAULT_RESET_PC : default first fetch address
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,  // request outstanding at pc
        ST_HOLD   = 2'd1,  // fetched word parked in buffer while decode stalls
        ST_SQUASH = 2'd2   // waiting out a stale request after a redirect
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Issues one request per instruction to instruction memory and loads the
// returned word into IF/ID. A stall that arrives with an acknowledge parks
// the word in a one-entry buffer so nothing is lost or refetched. A branch
// redirect that arrives while a request is still outstanding waits in
// SQUASH for that (now stale) response before switching to the target.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   imem_req/imem_addr    fetch request and word address (= pc)
//   imem_ack/imem_rdata   acknowledge and instruction word (same cycle)
//   stall                 decode hazard hold, IF/ID keeps its contents
//   branch_taken/target   redirect; beats stall; target[1:0] ignored
//   if_id_valid/pc/instr  IF/ID register
//   if_id_opcode          if_id_instr[6:0] for the decode control unit
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [6:0]  if_id_opcode
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic         v_q, v_d;
    logic [31:0]  ipc_q, ipc_d;
    logic [31:0]  iin_q, iin_d;

    logic [31:0]  target_al;
    logic [31:0]  pc_inc;
    logic         unused_tgt_bits;

    assign target_al       = {branch_target[31:2], 2'b00};
    assign unused_tgt_bits = ^branch_target[1:0];
    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
    assign pc_inc          = pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            tgt_q       <= 32'd0;
            buf_pc_q    <= 32'd0;
            buf_instr_q <= NOP_INSTR;
            v_q         <= 1'b0;
            ipc_q       <= 32'd0;
            iin_q       <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            v_q         <= v_d;
            ipc_q       <= ipc_d;
            iin_q       <= iin_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        v_d         = v_q;
        ipc_d       = ipc_q;
        iin_d       = iin_q;

        case (state_q)
            ST_REQ: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        // Returned word is on the wrong path; drop it.
                        v_d  = 1'b0;
                        pc_d = target_al;
                    end else if (!stall) begin
                        v_d   = 1'b1;
                        ipc_d = pc_q;
                        iin_d = imem_rdata;
                        pc_d  = pc_inc;
                    end else begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_rdata;
                        pc_d        = pc_inc;
                        state_d     = ST_HOLD;
                    end
                end else begin
                    if (branch_taken) begin
                        // Request already on the bus; address must stay
                        // stable until it is acknowledged.
                        v_d     = 1'b0;
                        tgt_d   = target_al;
                        state_d = ST_SQUASH;
                    end else if (!stall) begin
                        v_d = 1'b0;
                    end
                end
            end

            ST_HOLD: begin
                if (branch_taken) begin
                    v_d         = 1'b0;
                    pc_d        = target_al;
                    buf_pc_d    = 32'd0;
                    buf_instr_d = NOP_INSTR;
                    state_d     = ST_REQ;
                end else if (!stall) begin
                    v_d     = 1'b1;
                    ipc_d   = buf_pc_q;
                    iin_d   = buf_instr_q;
                    state_d = ST_REQ;
                end
            end

            ST_SQUASH: begin
                if (branch_taken) begin
                    v_d   = 1'b0;
                    tgt_d = target_al;
                end
                if (imem_ack) begin
                    // Latest redirect wins, including one in the ack cycle.
                    pc_d    = branch_taken ? target_al : tgt_q;
                    state_d = ST_REQ;
                end
            end

            default: state_d = ST_REQ;
        endcase
    end

    assign imem_req     = (state_q != ST_HOLD);
    assign imem_addr    = pc_q;
    assign if_id_valid  = v_q;
    assign if_id_pc     = ipc_q;
    assign if_id_instr  = iin_q;
    assign if_id_opcode = iin_q[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A memory responder with programmable
// acknowledge latency serves words from a fixed table. Expected IF/ID
// entries are queued as stimulus is issued; a monitor pops one whenever
// decode consumes a live entry (valid and not stalled) at the falling edge.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_opcode (if_id_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory responder ----------------
    logic mem_en;
    int   lat;
    int   cnt;

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0:   word = 32'h0000_0033;
            32'h4:   word = 32'h0000_2083;
            32'h8:   word = 32'h0040_2023;
            32'hC:   word = 32'h0020_8463;
            default: word = {a[23:0], 8'h13};
        endcase
    endfunction

    assign imem_ack   = mem_en && imem_req && (cnt >= lat);
    assign imem_rdata = imem_ack ? word(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk or posedge rst) begin
        if (rst)                                  cnt <= 0;
        else if (!(mem_en && imem_req) || imem_ack) cnt <= 0;
        else                                      cnt <= cnt + 1;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        rst           = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        mem_en        = 1'b0;
        lat           = 0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && if_id_valid && !stall) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ifid_pc", if_id_pc, 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("sb_pc", if_id_pc, e.pc);
                        chk("sb_instr", if_id_instr, e.instr);
                        chk("sb_opcode", {25'd0, if_id_opcode}, {25'd0, e.instr[6:0]});
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values without any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_valid",  {31'd0, if_id_valid}, 32'd0);
        chk("rst_pc",     if_id_pc, 32'd0);
        chk("rst_instr",  if_id_instr, 32'h0000_0013);
        chk("rst_opcode", {25'd0, if_id_opcode}, 32'h13);
        chk("rst_addr",   imem_addr, 32'd0);
        repeat (2) tick;

        // Streaming with combinational ack, then a 3-cycle stall at 0x8.
        rst    = 1'b0;
        mem_en = 1'b1;
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        push(32'h0, 32'h0000_0033);
        push(32'h4, 32'h0000_2083);
        push(32'h8, 32'h0040_2023);
        push(32'hC, 32'h0020_8463);
        tick;
        chk("e1_pc",  if_id_pc, 32'h0);
        chk("e1_opc", {25'd0, if_id_opcode}, 32'h33);
        tick;
        chk("e2_pc",  if_id_pc, 32'h4);
        chk("e2_opc", {25'd0, if_id_opcode}, 32'h03);
        stall = 1'b1;
        tick;
        chk("hold_req",   {31'd0, imem_req}, 32'd0);
        chk("hold_addr",  imem_addr, 32'hC);
        chk("hold_ifpc",  if_id_pc, 32'h4);
        chk("hold_valid", {31'd0, if_id_valid}, 32'd1);
        tick;
        tick;
        chk("hold3_ifpc", if_id_pc, 32'h4);
        stall = 1'b0;
        tick;
        chk("rel_ifpc", if_id_pc, 32'h8);
        chk("rel_addr", imem_addr, 32'hC);
        tick;
        chk("next_ifpc", if_id_pc, 32'hC);
        mem_en = 1'b0;
        tick;
        chk("bubble_valid", {31'd0, if_id_valid}, 32'd0);
        chk("bubble_addr",  imem_addr, 32'h10);

        // Branch during a slow fetch: stale word must be squashed.
        lat           = 2;
        mem_en        = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h103;
        tick;
        chk("sq_valid", {31'd0, if_id_valid}, 32'd0);
        chk("sq_req",   {31'd0, imem_req}, 32'd1);
        chk("sq_addr",  imem_addr, 32'h10);
        branch_taken = 1'b0;
        push(32'h100, 32'h0001_0013);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (imem_addr == 32'h100) seen = 1'b1;
            if (if_id_valid) break;
        end
        chk("sq_seen100", {31'd0, seen}, 32'd1);
        chk("sq_valid_end", {31'd0, if_id_valid}, 32'd1);
        chk("sq_ifpc", if_id_pc, 32'h100);
        mem_en = 1'b0;
        tick;

        // Branch together with stall while in HOLD.
        lat    = 0;
        mem_en = 1'b1;
        tick;
        chk("t4_ifpc", if_id_pc, 32'h104);
        stall = 1'b1;
        tick;
        chk("t4_hold_req", {31'd0, imem_req}, 32'd0);
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        tick;
        chk("t4_valid", {31'd0, if_id_valid}, 32'd0);
        chk("t4_addr",  imem_addr, 32'h200);
        chk("t4_req",   {31'd0, imem_req}, 32'd1);
        branch_taken = 1'b0;
        tick;
        stall = 1'b0;
        push(32'h200, 32'h0002_0013);
        tick;
        chk("t4_ifpc_after", if_id_pc, 32'h200);
        mem_en = 1'b0;
        tick;

        // PC wrap at the top of the address space.
        mem_en        = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        tick;
        chk("wrap_addr",  imem_addr, 32'hFFFF_FFFC);
        chk("wrap_valid", {31'd0, if_id_valid}, 32'd0);
        branch_taken = 1'b0;
        push(32'hFFFF_FFFC, 32'hFFFF_FC13);
        tick;
        chk("wrap_next", imem_addr, 32'h0);
        mem_en = 1'b0;
        tick;

        // Asynchronous reset while a request is pending.
        mem_en = 1'b1;
        tick;
        mem_en = 1'b0;
        stall  = 1'b1;
        tick;
        chk("pre_rst_valid", {31'd0, if_id_valid}, 32'd1);
        chk("pre_rst_addr",  imem_addr, 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("arst_pc",    if_id_pc, 32'd0);
        chk("arst_instr", if_id_instr, 32'h0000_0013);
        chk("arst_addr",  imem_addr, 32'd0);
        stall = 1'b0;
        tick;
        rst    = 1'b0;
        mem_en = 1'b1;
        chk("post_rst_req",  {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'd0);
        push(32'h0, 32'h0000_0033);
        tick;
        chk("post_rst_ifpc", if_id_pc, 32'h0);
        mem_en = 1'b0;
        tick;
        tick;
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
